// File: rtl/heart_rate_est.sv
// PPG beat detector with hysteresis, IBI measurement, outlier rejection, windowed average and BPM divide.
// Latency: o_beat_pulse 1 cycle after the crossing sample; o_bpm/o_bpm_valid 20 cycles after o_beat_pulse.
// Backpressure: none; strobe-driven input, all outputs are strobes or levels with no ready handshake.
module heart_rate_est #(
    parameter int DATA_WIDTH = 18,
    parameter int P_SYS_CLK  = 50_000_000,
    parameter int AVG_LOG2   = 2,
    parameter int MIN_IBI_MS = 300,
    parameter int MAX_IBI_MS = 2000,
    parameter int TIMEOUT_MS = 2500,
    parameter int BPM_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_data_valid,
    input  logic signed [DATA_WIDTH-1:0] i_ac_data,
    input  logic signed [DATA_WIDTH-1:0] i_thr_high,
    input  logic signed [DATA_WIDTH-1:0] i_thr_low,
    output logic                         o_beat_pulse,
    output logic [15:0]                  o_ibi_ms,
    output logic                         o_reject,
    output logic [BPM_WIDTH-1:0]         o_bpm,
    output logic                         o_bpm_valid,
    output logic                         o_no_signal
);

    localparam int TICK_DIV = P_SYS_CLK / 1000;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DEPTH    = 1 << AVG_LOG2;
    localparam int SUM_W    = 16 + AVG_LOG2;
    localparam int FILL_W   = AVG_LOG2 + 1;
    localparam int PTR_W    = AVG_LOG2;
    localparam logic [16:0] DIVIDEND = 17'd60000;
    localparam logic [16:0] BPM_MAX  = 17'((1 << BPM_WIDTH) - 1);

    // ---------------------------------------------------------------
    // Beat detector
    // ---------------------------------------------------------------
    typedef enum logic {FIND_PEAK, FIND_TROUGH} det_state_t;
    det_state_t det_state, det_next;
    logic       beat_det;

    // Detector state register
    always_ff @(posedge clk) begin
        if (rst) det_state <= FIND_PEAK;
        else     det_state <= det_next;
    end

    // Hysteresis transitions, only on valid samples, strict signed compares
    always_comb begin
        det_next = det_state;
        if (i_data_valid) begin
            case (det_state)
                FIND_PEAK:   if (i_ac_data > i_thr_high) det_next = FIND_TROUGH;
                FIND_TROUGH: if (i_ac_data < i_thr_low)  det_next = FIND_PEAK;
                default:     det_next = FIND_PEAK;
            endcase
        end
    end

    // Beat request: rising crossing of the peak threshold while looking for a peak
    always_comb begin
        beat_det = i_data_valid && (det_state == FIND_PEAK) && (i_ac_data > i_thr_high);
    end

    // Register the request into a one-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) o_beat_pulse <= 1'b0;
        else     o_beat_pulse <= beat_det;
    end

    // ---------------------------------------------------------------
    // Millisecond tick and IBI counter
    // ---------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt;
    logic              ms_tick;
    logic [15:0]       ibi_cnt;
    logic              timeout_hit;

    assign ms_tick     = (tick_cnt == TICK_W'(TICK_DIV - 1));
    // Only the transition onto TIMEOUT_MS counts; a saturated counter does not re-fire
    assign timeout_hit = ms_tick && !o_beat_pulse && (ibi_cnt == 16'(TIMEOUT_MS - 1));

    // Free-running ms prescaler
    always_ff @(posedge clk) begin
        if (rst || ms_tick) tick_cnt <= '0;
        else                tick_cnt <= tick_cnt + TICK_W'(1);
    end

    // Interval counter: a beat clears it and swallows a coincident tick
    always_ff @(posedge clk) begin
        if (rst || o_beat_pulse)
            ibi_cnt <= '0;
        else if (ms_tick && (ibi_cnt != 16'(TIMEOUT_MS)))
            ibi_cnt <= ibi_cnt + 16'd1;
    end

    // Loss-of-signal level: set on timeout, cleared by the next beat
    always_ff @(posedge clk) begin
        if (rst)               o_no_signal <= 1'b1;
        else if (o_beat_pulse) o_no_signal <= 1'b0;
        else if (timeout_hit)  o_no_signal <= 1'b1;
    end

    // ---------------------------------------------------------------
    // Interval capture and acceptance
    // ---------------------------------------------------------------
    logic              eval_vld;
    logic [15:0]       eval_ibi;
    logic              eval_discard;
    logic [15:0]       hist [DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [FILL_W-1:0] fill;
    logic [SUM_W-1:0]  sum;
    logic [1:0]        rej_cnt;
    logic [15:0]       avg;
    logic [15:0]       diff;
    logic              full, in_range, is_reject, is_accept, flush_rej;

    // Snapshot the interval at the beat; the first beat after loss of signal is discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            eval_vld     <= 1'b0;
            eval_ibi     <= '0;
            eval_discard <= 1'b0;
        end else begin
            eval_vld <= o_beat_pulse;
            if (o_beat_pulse) begin
                eval_ibi     <= ibi_cnt;
                eval_discard <= o_no_signal;
            end
        end
    end

    assign avg      = 16'(sum >> AVG_LOG2);
    assign full     = (fill == FILL_W'(DEPTH));
    assign in_range = (eval_ibi >= 16'(MIN_IBI_MS)) && (eval_ibi <= 16'(MAX_IBI_MS));
    assign diff     = (eval_ibi >= avg) ? (eval_ibi - avg) : (avg - eval_ibi);

    // Accept/reject decision; out-of-range intervals fall through silently
    always_comb begin
        is_reject = eval_vld && !eval_discard && in_range && full && (diff > (avg >> 2));
        is_accept = eval_vld && !eval_discard && in_range && !is_reject;
        flush_rej = is_reject && (rej_cnt == 2'd2);
    end

    // History ring, running sum, fill level, reject streak and IBI/reject outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            ptr      <= '0;
            fill     <= '0;
            sum      <= '0;
            rej_cnt  <= '0;
            o_ibi_ms <= '0;
            o_reject <= 1'b0;
        end else begin
            o_reject <= is_reject;
            if (timeout_hit) begin
                ptr     <= '0;
                fill    <= '0;
                sum     <= '0;
                rej_cnt <= '0;
            end else if (is_reject) begin
                if (flush_rej) begin
                    ptr     <= '0;
                    fill    <= '0;
                    sum     <= '0;
                    rej_cnt <= '0;
                end else begin
                    rej_cnt <= rej_cnt + 2'd1;
                end
            end else if (is_accept) begin
                hist[ptr] <= eval_ibi;
                ptr       <= ptr + PTR_W'(1);
                // Until the window is full the slot being written holds nothing counted in sum
                sum       <= sum + SUM_W'(eval_ibi) - (full ? SUM_W'(hist[ptr]) : '0);
                fill      <= full ? fill : fill + FILL_W'(1);
                rej_cnt   <= '0;
                o_ibi_ms  <= eval_ibi;
            end
        end
    end

    // ---------------------------------------------------------------
    // BPM divider: 60000 / avg, restoring, one quotient bit per cycle
    // ---------------------------------------------------------------
    typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;
    div_state_t     div_state, div_next;
    logic           start_q, pend;
    logic           div_load, div_last;
    logic [16:0]    dvd;
    logic [15:0]    dvs;
    logic [15:0]    rem;
    logic [15:0]    quo;
    logic [4:0]     iter;
    logic [16:0]    rem_sh;
    logic           rem_ge;
    logic [15:0]    rem_nx;
    logic [16:0]    quo_nx;
    logic [BPM_WIDTH-1:0] bpm_res;

    // Divide request lands the cycle after an accept that leaves the window full
    always_ff @(posedge clk) begin
        if (rst) start_q <= 1'b0;
        else     start_q <= is_accept && (full || (fill == FILL_W'(DEPTH - 1)));
    end

    // One-deep pending request while the divider is busy
    always_ff @(posedge clk) begin
        if (rst || timeout_hit) pend <= 1'b0;
        else if (div_load)      pend <= 1'b0;
        else if (start_q)       pend <= 1'b1;
    end

    // Divider state register
    always_ff @(posedge clk) begin
        if (rst) div_state <= DIV_IDLE;
        else     div_state <= div_next;
    end

    // Divider next state; a timeout abandons an in-flight divide
    always_comb begin
        div_next = div_state;
        case (div_state)
            DIV_IDLE: if (div_load) div_next = DIV_BUSY;
            DIV_BUSY: if (timeout_hit || div_last) div_next = DIV_IDLE;
            default:  div_next = DIV_IDLE;
        endcase
    end

    // Divider control decodes and one restoring step
    always_comb begin
        div_load = (div_state == DIV_IDLE) && (start_q || pend) && !timeout_hit;
        div_last = (div_state == DIV_BUSY) && (iter == 5'd16) && !timeout_hit;
        rem_sh   = {rem, dvd[16]};
        rem_ge   = (rem_sh >= {1'b0, dvs});
        rem_nx   = rem_ge ? 16'(rem_sh - {1'b0, dvs}) : rem_sh[15:0];
        quo_nx   = {quo, rem_ge};
        bpm_res  = (quo_nx > BPM_MAX) ? '1 : quo_nx[BPM_WIDTH-1:0];
    end

    // Divider datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd  <= '0;
            dvs  <= '0;
            rem  <= '0;
            quo  <= '0;
            iter <= '0;
        end else if (div_load) begin
            dvd  <= DIVIDEND;
            dvs  <= avg;
            rem  <= '0;
            quo  <= '0;
            iter <= '0;
        end else if (div_state == DIV_BUSY) begin
            dvd  <= {dvd[15:0], 1'b0};
            rem  <= rem_nx;
            quo  <= quo_nx[15:0];
            iter <= iter + 5'd1;
        end
    end

    // BPM output: cleared on loss of signal, updated with a strobe when a divide completes
    always_ff @(posedge clk) begin
        if (rst) begin
            o_bpm       <= '0;
            o_bpm_valid <= 1'b0;
        end else begin
            o_bpm_valid <= 1'b0;
            if (timeout_hit) begin
                o_bpm <= '0;
            end else if (div_last) begin
                o_bpm       <= bpm_res;
                o_bpm_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/heart_rate_est.md
Name: heart_rate_est

Overview:
Parametrised successor to the fixed-threshold PPG beat detector and BPM calculator. It takes the band-passed AC stream from the MAX30102 filter chain and detects beats with runtime-programmable hysteresis. It measures inter-beat intervals (IBI) in ms, rejects outliers, and averages IBI over a power-of-two window. It then converts the average to BPM with a fixed-latency restoring divider and drives the display/UART status path.

Parameters:
DATA_WIDTH, 18, width of signed AC sample and thresholds
P_SYS_CLK, 50_000_000, clk frequency in Hz; ms tick = P_SYS_CLK/1000 cycles
AVG_LOG2, 2, averaging window depth = 2^AVG_LOG2 accepted IBIs (legal 1..4)
MIN_IBI_MS, 300, smallest accepted IBI (200 bpm)
MAX_IBI_MS, 2000, largest accepted IBI (30 bpm)
TIMEOUT_MS, 2500, beat-free time that declares loss of signal (> MAX_IBI_MS)
BPM_WIDTH, 8, output BPM width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
i_data_valid  in  1  one-cycle strobe, i_ac_data valid
i_ac_data  in  DATA_WIDTH signed  filtered AC sample
i_thr_high  in  DATA_WIDTH signed  peak threshold
i_thr_low  in  DATA_WIDTH signed  trough threshold (caller keeps < i_thr_high)
o_beat_pulse  out  1  one-cycle beat strobe
o_ibi_ms  out  16  last accepted IBI
o_reject  out  1  one-cycle strobe, IBI rejected
o_bpm  out  BPM_WIDTH  averaged BPM
o_bpm_valid  out  1  one-cycle strobe, o_bpm updated
o_no_signal  out  1  level, no beat for TIMEOUT_MS

Behaviour:
- Only clock is clk. All state updates on the rising edge. rst is synchronous, active-high, and overrides everything, including an in-flight divide.
- Reset values: o_beat_pulse=0, o_ibi_ms=0, o_reject=0, o_bpm=0, o_bpm_valid=0, o_no_signal=1. Detector is in FIND_PEAK; all counters, history and fill count are 0; divider is IDLE.
- Beat detector FSM, evaluated only when i_data_valid=1, with strict signed compares:
  - FIND_PEAK: if i_ac_data > i_thr_high, go to FIND_TROUGH and assert o_beat_pulse on the next cycle.
  - FIND_TROUGH: if i_ac_data < i_thr_low, go to FIND_PEAK.
  - o_beat_pulse is high for exactly one clk and never persists across samples.
- ms tick: a counter runs 0..P_SYS_CLK/1000-1 and ticks on the terminal count, free-running from reset.
- IBI counter:
  - Increments on tick and saturates at TIMEOUT_MS.
  - On o_beat_pulse the counter is evaluated, then cleared to 0. If a beat and a tick fall in the same cycle, the beat wins and the tick is dropped.
  - On reaching TIMEOUT_MS: set o_no_signal, flush history (fill=0, sum=0), set o_bpm=0. No o_bpm_valid is generated.
  - The next beat clears o_no_signal. That first beat's interval is discarded as out of range.
- Acceptance, decided in the cycle after o_beat_pulse:
  - Range: an IBI is in range when MIN_IBI_MS <= IBI <= MAX_IBI_MS. Out-of-range IBIs are silently dropped with no o_reject.
  - If history is full (fill = 2^AVG_LOG2), avg = sum >> AVG_LOG2. An in-range IBI with |IBI - avg| > avg>>2 pulses o_reject for one cycle.
  - Three consecutive rejects flush history. The third rejected IBI is not stored.
  - Otherwise the IBI is accepted: update o_ibi_ms, push into the circular history, sum = sum + new - evicted, fill saturates at depth, and the reject count clears.
- Divider:
  - Starts on the cycle after an accept, and only when fill = depth.
  - Computes 17-bit dividend 60000 / 16-bit divisor avg as a restoring shift-subtract, one quotient bit per cycle, 17 iterations. The quotient is truncated.
  - Quotient > 2^BPM_WIDTH-1 saturates to all-ones.
  - o_bpm and o_bpm_valid are updated exactly 20 cycles after the o_beat_pulse cycle.
  - A start request while busy sets a one-deep pending flag, and the divide restarts with the current avg when IDLE.
- Sum width is 16+AVG_LOG2 bits, so no overflow is possible.

Test Plan:
1. P_SYS_CLK=10_000, thresholds ±100. Drive a sine of amplitude 500 with period 800 ms for 6 beats: o_bpm_valid fires first on the 5th beat (4th accepted IBI); o_bpm=75, o_ibi_ms=800, and o_bpm_valid lands 20 cycles after that beat's o_beat_pulse.
2. After #1, insert one 1100 ms interval (|300| > 200): o_reject pulses, o_bpm stays 75. Three consecutive 1100 ms intervals: history flushes, and after 4 further 1100 ms IBIs o_bpm=54.
3. Samples oscillating between +150 and +50 with thresholds ±100 produce only one o_beat_pulse (no trough crossed). A sample exactly equal to i_thr_high produces no beat.
4. Stop beats after a lock: o_no_signal rises exactly 2500 ms after the last beat and o_bpm=0. The next beat clears o_no_signal, and BPM output reappears only after 4 more accepted IBIs.
5. IBIs of 300 ms and 2000 ms are both accepted (BPM 200 and 30). 299 ms and 2001 ms are dropped, with no o_reject.
6. Assert rst for 1 cycle mid-divide: all outputs return to their reset values next cycle, and no o_bpm_valid follows.
